clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
Controller that sequences the 12-hour BCD time-of-day counter.
- Generates the once-per-second `ena` tick from the system clock.
- Runs a button-driven set-mode FSM in which the user edits the hour, then the minute.
- Commits the edited time to the counter with a one-cycle load pulse.
- Sits between the debounced front-panel buttons and the time counter. Display logic reads `cur_*` and the blink flag.

Parameters:
- TICK_DIV, 100000000, clk cycles per `ena` pulse; legal range ≥ 2.
- BLINK_DIV, 50000000, clk cycles per `blink` toggle in set mode; legal range ≥ 1.
- TIMEOUT_TICKS, 30, tick periods without a button in a set state before abandoning the edit; legal range ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- btn_mode  in  1  single-cycle pulse from debouncer: enter/advance/commit set mode
- btn_inc  in  1  single-cycle pulse from debouncer: increment the field being edited
- cur_hh  in  8  counter hour, BCD, 01..12
- cur_mm  in  8  counter minute, BCD, 00..59
- cur_pm  in  1  counter pm flag
- ena  out  1  count-enable tick to the counter
- load  out  1  one-cycle load strobe; the counter takes `load_hh`, `load_mm` and `load_pm`, and clears seconds
- load_hh  out  8  edited hour, BCD, 01..12
- load_mm  out  8  edited minute, BCD, 00..59
- load_pm  out  1  edited pm flag
- set_mode  out  2  0 = RUN, 1 = SET_HH, 2 = SET_MM, 3 = COMMIT
- blink  out  1  display blink phase for the field being edited; 0 in RUN

Behaviour:
- Reset values:
  - state RUN, prescaler 0, blink counter 0, timeout counter 0.
  - `ena` = 0, `load` = 0, `blink` = 0, `set_mode` = 0.
  - Edit registers: hh = 8'h12, mm = 8'h00, pm = 0; `load_*` drive these.
  - Reset mid-edit discards the edit; no `load` is issued.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `ena` = 1 for exactly the cycle in which the count equals TICK_DIV-1 and the state is RUN; otherwise `ena` = 0. The prescaler keeps counting in set states and drives the timeout.
- RUN:
  - On `btn_mode`: capture `cur_hh`, `cur_mm` and `cur_pm` into the edit registers, go to SET_HH, clear the timeout counter.
  - `btn_inc` is ignored.
- SET_HH:
  - On `btn_inc`: hour advances 12→01→02…→11→12.
  - The 11→12 step toggles the edit pm flag. BCD arithmetic: 09→10, 12→01.
  - On `btn_mode`: go to SET_MM.
- SET_MM:
  - On `btn_inc`: minute advances 00→01…→59→00.
  - BCD arithmetic: x9→(x+1)0. No carry into the hour.
  - On `btn_mode`: go to COMMIT.
- COMMIT: lasts one cycle. `load` = 1 with `load_*` = edit registers. Next state RUN, prescaler cleared to 0, so the first `ena` comes exactly TICK_DIV cycles after the `load` cycle.
- Simultaneous `btn_mode` and `btn_inc`: `btn_mode` wins and `btn_inc` is dropped in every state.
- Buttons during COMMIT are ignored.
- Timeout:
  - In SET_HH or SET_MM, the timeout counter increments at each prescaler wrap and clears on any button pulse.
  - On reaching TIMEOUT_TICKS, go to RUN without `load`; the edit registers are kept but unused.
  - The prescaler is not cleared, so ticking resumes on the original phase.
- Blink:
  - Toggles every BLINK_DIV cycles in SET_HH and SET_MM.
  - Forced to 0, and its counter cleared, in RUN and COMMIT.
  - Restarts at 1 on entry to each set state.
- All outputs are registered; `ena` and `load` are never high in the same cycle.

Test Plan:
- Reset, then run 3*TICK_DIV cycles with TICK_DIV = 4 → `ena` pulses at cycles 3, 7 and 11 after reset release; `load` stays 0; `set_mode` = 0.
- `cur` = 11:58 am; `btn_mode`; `btn_inc`; `btn_mode`; 3×`btn_inc`; `btn_mode` → `load` high for one cycle with `load_hh` = 8'h12, `load_mm` = 8'h01, `load_pm` = 1; next `ena` exactly TICK_DIV cycles later.
- In SET_HH from 09, 4×`btn_inc` → hour sequence 10, 11, 12, 01; pm toggles only on 11→12.
- `btn_mode` and `btn_inc` asserted in the same cycle in SET_HH → state becomes SET_MM and the hour is unchanged.
- TIMEOUT_TICKS = 2, TICK_DIV = 4; enter SET_HH and idle → returns to RUN on the 2nd prescaler wrap with no `load`; `ena` resumes on the original phase.
- Assert `reset` while in SET_MM → next cycle `set_mode` = 0, `load` = 0, `load_hh` = 8'h12, `load_mm` = 8'h00, `blink` = 0.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// Time-of-day controller: 1 Hz tick prescaler, button-driven set-mode FSM, and
// load-strobe generation for the 12-hour BCD time counter.
//   state  | meaning
//   RUN    | counter runs on ena; btn_mode starts an edit
//   SET_HH | editing hour (blinking)
//   SET_MM | editing minute (blinking)
//   COMMIT | one-cycle load of the edited time
module clock_time_ctrl #(
  parameter int TICK_DIV      = 100000000,
  parameter int BLINK_DIV     = 50000000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic       cur_pm,
  output logic       ena,
  output logic       load,
  output logic [7:0] load_hh,
  output logic [7:0] load_mm,
  output logic       load_pm,
  output logic [1:0] set_mode,
  output logic       blink
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, COMMIT = 2'd3} state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tmo;
  logic [7:0]    hh, mm;
  logic          pm;
  logic          presc_wrap;
  logic [7:0]    hh_inc, mm_inc;

  assign presc_wrap = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    hh_inc = hh + 8'h01;
    if (hh == 8'h12)      hh_inc = 8'h01;
    else if (hh == 8'h09) hh_inc = 8'h10;
    mm_inc = mm + 8'h01;
    if (mm == 8'h59)           mm_inc = 8'h00;
    else if (mm[3:0] == 4'h9)  mm_inc = {mm[7:4] + 4'h1, 4'h0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      presc <= '0;
      bcnt  <= '0;
      tmo   <= '0;
      hh    <= 8'h12;
      mm    <= 8'h00;
      pm    <= 1'b0;
      ena   <= 1'b0;
      load  <= 1'b0;
      blink <= 1'b0;
    end else begin
      ena   <= 1'b0;
      load  <= 1'b0;
      presc <= presc_wrap ? '0 : presc + 1'b1;
      case (state)
        RUN: begin
          blink <= 1'b0;
          bcnt  <= '0;
          if (btn_mode) begin
            hh    <= cur_hh;
            mm    <= cur_mm;
            pm    <= cur_pm;
            tmo   <= '0;
            blink <= 1'b1;
            state <= SET_HH;
          end else begin
            // registered tick: fires in the cycle the prescaler sits at TICK_DIV-1
            ena <= (presc == PW'(TICK_DIV - 2));
          end
        end
        SET_HH, SET_MM: begin
          if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            blink <= ~blink;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
          if (btn_mode) begin
            tmo  <= '0;
            bcnt <= '0;
            if (state == SET_HH) begin
              blink <= 1'b1;
              state <= SET_MM;
            end else begin
              blink <= 1'b0;
              load  <= 1'b1;
              state <= COMMIT;
            end
          end else if (btn_inc) begin
            tmo <= '0;
            if (state == SET_HH) begin
              hh <= hh_inc;
              if (hh == 8'h11) pm <= ~pm;
            end else begin
              mm <= mm_inc;
            end
          end else if (presc_wrap) begin
            // abandon the edit; prescaler keeps its phase
            if ((tmo + 1'b1) == TW'(TIMEOUT_TICKS)) begin
              tmo   <= '0;
              bcnt  <= '0;
              blink <= 1'b0;
              state <= RUN;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
        end
        COMMIT: begin
          presc <= '0;
          bcnt  <= '0;
          blink <= 1'b0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign set_mode = state;
  assign load_hh  = hh;
  assign load_mm  = mm;
  assign load_pm  = pm;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICK_DIV=4, BLINK_DIV=3, TIMEOUT_TICKS=2.
module tb_clock_time_ctrl;
  logic       clk = 1'b0;
  logic       reset, btn_mode, btn_inc, cur_pm;
  logic [7:0] cur_hh, cur_mm;
  logic       ena, load, load_pm, blink;
  logic [7:0] load_hh, load_mm;
  logic [1:0] set_mode;
  int checks = 0;
  int errors = 0;
  int ph = 0;

  clock_time_ctrl #(.TICK_DIV(4), .BLINK_DIV(3), .TIMEOUT_TICKS(2)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_pm(cur_pm),
    .ena(ena), .load(load), .load_hh(load_hh), .load_mm(load_mm),
    .load_pm(load_pm), .set_mode(set_mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hh = 8'h12; cur_mm = 8'h00; cur_pm = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    ph = 0;

    // reset state
    chk("rst_ena", ena, 0);
    chk("rst_load", load, 0);
    chk("rst_blink", blink, 0);
    chk("rst_mode", set_mode, 0);
    chk("rst_hh", load_hh, 8'h12);
    chk("rst_mm", load_mm, 8'h00);
    chk("rst_pm", load_pm, 0);

    // free-running ticks at cycles 3, 7, 11
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("run_ena_c%0d", c), ena, (c % 4 == 3) ? 1 : 0);
      chk("run_load", load, 0);
      chk("run_mode", set_mode, 0);
    end

    // btn_inc ignored in RUN
    press(1'b0, 1'b1);
    chk("run_inc_mode", set_mode, 0);
    chk("run_inc_hh", load_hh, 8'h12);

    // edit 11:58 am -> 12:01 pm
    cur_hh = 8'h11; cur_mm = 8'h58; cur_pm = 1'b0;
    press(1'b1, 1'b0);
    chk("e_mode_hh", set_mode, 1);
    chk("e_cap_hh", load_hh, 8'h11);
    chk("e_cap_mm", load_mm, 8'h58);
    chk("e_blink_entry", blink, 1);
    press(1'b0, 1'b1);
    chk("e_hh12", load_hh, 8'h12);
    chk("e_pm", load_pm, 1);
    press(1'b1, 1'b0);
    chk("e_mode_mm", set_mode, 2);
    chk("e_blink_mm_entry", blink, 1);
    press(1'b0, 1'b1);
    chk("e_mm59", load_mm, 8'h59);
    press(1'b0, 1'b1);
    chk("e_mm00", load_mm, 8'h00);
    chk("e_no_carry", load_hh, 8'h12);
    press(1'b0, 1'b1);
    chk("e_mm01", load_mm, 8'h01);
    press(1'b1, 1'b0);
    chk("c_mode", set_mode, 3);
    chk("c_load", load, 1);
    chk("c_hh", load_hh, 8'h12);
    chk("c_mm", load_mm, 8'h01);
    chk("c_pm", load_pm, 1);
    chk("c_ena", ena, 0);
    chk("c_blink", blink, 0);
    tick();
    ph = 0;
    chk("c1_load", load, 0);
    chk("c1_mode", set_mode, 0);
    chk("c1_ena", ena, 0);
    tick();
    chk("c2_ena", ena, 0);
    tick();
    chk("c3_ena", ena, 0);
    tick();
    chk("c4_ena", ena, 1);

    // hour rollover from 09 pm
    cur_hh = 8'h09; cur_mm = 8'h09; cur_pm = 1'b1;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("h10", load_hh, 8'h10);
    chk("h10_pm", load_pm, 1);
    press(1'b0, 1'b1);
    chk("h11", load_hh, 8'h11);
    chk("h11_pm", load_pm, 1);
    press(1'b0, 1'b1);
    chk("h12", load_hh, 8'h12);
    chk("h12_pm", load_pm, 0);
    press(1'b0, 1'b1);
    chk("h01", load_hh, 8'h01);
    chk("h01_pm", load_pm, 0);

    // simultaneous buttons: mode wins
    press(1'b1, 1'b1);
    chk("sim_mode", set_mode, 2);
    chk("sim_hh", load_hh, 8'h01);
    press(1'b0, 1'b1);
    chk("m09_10", load_mm, 8'h10);
    press(1'b1, 1'b0);
    chk("c2_load", load, 1);
    chk("c2_hh", load_hh, 8'h01);
    chk("c2_mm", load_mm, 8'h10);
    tick();
    ph = 0;
    chk("c2_back_run", set_mode, 0);

    // timeout: enter SET_HH on prescaler phase 0, idle through two wraps
    while (ph != 0) tick();
    cur_hh = 8'h07; cur_mm = 8'h30; cur_pm = 1'b0;
    press(1'b1, 1'b0);
    chk("t_mode", set_mode, 1);
    chk("t_blink0", blink, 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("t_mode_k%0d", k), set_mode, (k < 7) ? 1 : 0);
      chk($sformatf("t_blink_k%0d", k), blink, (k == 1 || k == 2 || k == 6) ? 1 : 0);
      chk("t_ena", ena, 0);
      chk("t_load", load, 0);
    end
    chk("t_kept_hh", load_hh, 8'h07);
    tick();
    chk("t_ena_ph1", ena, 0);
    tick();
    chk("t_ena_ph2", ena, 0);
    tick();
    chk("t_ena_ph3", ena, 1);

    // reset mid-edit in SET_MM
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("r_pre_mode", set_mode, 2);
    reset = 1'b1;
    tick();
    chk("r_mode", set_mode, 0);
    chk("r_load", load, 0);
    chk("r_hh", load_hh, 8'h12);
    chk("r_mm", load_mm, 8'h00);
    chk("r_pm", load_pm, 0);
    chk("r_blink", blink, 0);
    reset = 1'b0;
    tick();
    chk("r_after_load", load, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
